// File: rtl/mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rw_arbiter
// Description : Round-robin arbiter placing up to NUM_CH read/write clients
//               onto a single RAM port. One access at a time: IDLE grants,
//               ACCESS holds address/data until the RAM completes or the
//               timeout expires, RESP pulses done (and err on timeout) back
//               to the granted client.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               ch_rden_in/wren_in  - per-channel level requests
//               ch_addr_in/wdata_in - per-channel packed address / data
//               ch_done_out/err_out - one-hot completion / timeout pulses
//               rdata_out           - last read data returned
//               busy_out            - high while not IDLE
//               mem_*               - RAM port (enables, addr, data, done)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rw_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_rden_in,
    input  logic [NUM_CH-1:0]          ch_wren_in,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_in,
    input  logic [NUM_CH*WORD_W-1:0]   ch_wdata_in,
    output logic [NUM_CH-1:0]          ch_done_out,
    output logic [NUM_CH-1:0]          ch_err_out,
    output logic [WORD_W-1:0]          rdata_out,
    output logic                       busy_out,
    output logic                       mem_rden_out,
    output logic                       mem_wren_out,
    output logic [ADDR_W-1:0]          mem_addr_out,
    output logic [WORD_W-1:0]          mem_wdata_out,
    input  logic [WORD_W-1:0]          mem_rdata_in,
    input  logic                       mem_done_in
);

    localparam int c_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO  = c_CNT_W'(TIMEOUT);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_ch;
    logic                 r_is_rd;
    logic [c_CNT_W-1:0]   r_cnt;

    state_t               w_state;
    logic [c_IDX_W-1:0]   w_rr_ptr;
    logic [c_IDX_W-1:0]   w_ch;
    logic                 w_is_rd;
    logic [c_CNT_W-1:0]   w_cnt;
    logic [NUM_CH-1:0]    w_done;
    logic [NUM_CH-1:0]    w_err;
    logic [WORD_W-1:0]    w_rdata;
    logic                 w_busy;
    logic                 w_mem_rden;
    logic                 w_mem_wren;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic [WORD_W-1:0]    w_mem_wdata;

    logic [NUM_CH-1:0]    w_pend;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_gnt;

    logic [ADDR_W-1:0]    w_addr  [NUM_CH];
    logic [WORD_W-1:0]    w_wdata [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_addr[gi]  = ch_addr_in[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = ch_wdata_in[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign w_pend = ch_rden_in | ch_wren_in;

    // Round-robin search: first pending channel at or above rr_ptr, wrapping.
    always_comb begin
        int                 v_j;
        logic [c_IDX_W-1:0] v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_j     = 0;
        v_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_j = int'(r_rr_ptr) + k;
            if (v_j >= NUM_CH) begin
                v_j = v_j - NUM_CH;
            end
            v_idx = c_IDX_W'(v_j);
            if (!w_found && w_pend[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state     = r_state;
        w_rr_ptr    = r_rr_ptr;
        w_ch        = r_ch;
        w_is_rd     = r_is_rd;
        w_cnt       = r_cnt;
        w_done      = '0;
        w_err       = '0;
        w_rdata     = rdata_out;
        w_mem_rden  = mem_rden_out;
        w_mem_wren  = mem_wren_out;
        w_mem_addr  = mem_addr_out;
        w_mem_wdata = mem_wdata_out;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state     = ST_ACCESS;
                    w_ch        = w_gnt;
                    // Read wins when a client raises both enables.
                    w_is_rd     = ch_rden_in[w_gnt];
                    w_cnt       = '0;
                    w_mem_rden  = ch_rden_in[w_gnt];
                    w_mem_wren  = ~ch_rden_in[w_gnt];
                    w_mem_addr  = w_addr[w_gnt];
                    w_mem_wdata = ch_rden_in[w_gnt] ? '0 : w_wdata[w_gnt];
                end
            end
            ST_ACCESS: begin
                w_cnt = r_cnt + 1'b1;
                // A completion in the same cycle as expiry is a success.
                if (mem_done_in) begin
                    w_state      = ST_RESP;
                    w_done[r_ch] = 1'b1;
                    if (r_is_rd) begin
                        w_rdata = mem_rdata_in;
                    end
                    w_mem_rden  = 1'b0;
                    w_mem_wren  = 1'b0;
                    w_mem_addr  = '0;
                    w_mem_wdata = '0;
                end else if ((TIMEOUT != 0) && (w_cnt == c_TMO)) begin
                    w_state      = ST_RESP;
                    w_done[r_ch] = 1'b1;
                    w_err[r_ch]  = 1'b1;
                    w_rdata      = '0;
                    w_mem_rden   = 1'b0;
                    w_mem_wren   = 1'b0;
                    w_mem_addr   = '0;
                    w_mem_wdata  = '0;
                end
            end
            ST_RESP: begin
                w_state  = ST_IDLE;
                w_rr_ptr = (r_ch == c_LAST) ? '0 : r_ch + 1'b1;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_ch          <= '0;
            r_is_rd       <= 1'b0;
            r_cnt         <= '0;
            ch_done_out   <= '0;
            ch_err_out    <= '0;
            rdata_out     <= '0;
            busy_out      <= 1'b0;
            mem_rden_out  <= 1'b0;
            mem_wren_out  <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
        end else begin
            r_state       <= w_state;
            r_rr_ptr      <= w_rr_ptr;
            r_ch          <= w_ch;
            r_is_rd       <= w_is_rd;
            r_cnt         <= w_cnt;
            ch_done_out   <= w_done;
            ch_err_out    <= w_err;
            rdata_out     <= w_rdata;
            busy_out      <= w_busy;
            mem_rden_out  <= w_mem_rden;
            mem_wren_out  <= w_mem_wren;
            mem_addr_out  <= w_mem_addr;
            mem_wdata_out <= w_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rw_arbiter
// Description : Directed self-checking bench for mem_rw_arbiter (4 channels,
//               timeout of 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rw_arbiter;

    localparam int c_NUM_CH = 4;
    localparam int c_WORD_W = 32;
    localparam int c_ADDR_W = 16;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [c_NUM_CH-1:0]            ch_rden_in = '0;
    logic [c_NUM_CH-1:0]            ch_wren_in = '0;
    logic [c_NUM_CH*c_ADDR_W-1:0]   ch_addr_in = '0;
    logic [c_NUM_CH*c_WORD_W-1:0]   ch_wdata_in = '0;
    logic [c_NUM_CH-1:0]            ch_done_out;
    logic [c_NUM_CH-1:0]            ch_err_out;
    logic [c_WORD_W-1:0]            rdata_out;
    logic                           busy_out;
    logic                           mem_rden_out;
    logic                           mem_wren_out;
    logic [c_ADDR_W-1:0]            mem_addr_out;
    logic [c_WORD_W-1:0]            mem_wdata_out;
    logic [c_WORD_W-1:0]            mem_rdata_in = '0;
    logic                           mem_done_in = 1'b0;

    int checks   = 0;
    int failures = 0;

    mem_rw_arbiter #(
        .NUM_CH (c_NUM_CH),
        .WORD_W (c_WORD_W),
        .ADDR_W (c_ADDR_W),
        .TIMEOUT(4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ch_rden_in   (ch_rden_in),
        .ch_wren_in   (ch_wren_in),
        .ch_addr_in   (ch_addr_in),
        .ch_wdata_in  (ch_wdata_in),
        .ch_done_out  (ch_done_out),
        .ch_err_out   (ch_err_out),
        .rdata_out    (rdata_out),
        .busy_out     (busy_out),
        .mem_rden_out (mem_rden_out),
        .mem_wren_out (mem_wren_out),
        .mem_addr_out (mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in (mem_rdata_in),
        .mem_done_in  (mem_done_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ch_done_out, ch_err_out, busy_out} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: done=%b err=%b busy=%b required all 0",
                     ch_done_out, ch_err_out, busy_out);
        end
        checks++;
        if ({mem_rden_out, mem_wren_out, mem_addr_out, mem_wdata_out, rdata_out} !== '0) begin
            failures++;
            $display("FAIL reset_mem: rden=%b wren=%b addr=%h wdata=%h rdata=%h required all 0",
                     mem_rden_out, mem_wren_out, mem_addr_out, mem_wdata_out, rdata_out);
        end
    endtask

    // ch2 read, memory completes in the first ACCESS cycle.
    task automatic test_read();
        ch_addr_in[2*c_ADDR_W +: c_ADDR_W] = 16'h0100;
        ch_rden_in = 4'b0100;
        tick();
        checks++;
        if ({mem_rden_out, mem_wren_out, mem_addr_out, mem_wdata_out} !== {2'b10, 16'h0100, 32'h0}) begin
            failures++;
            $display("FAIL read_access: rden=%b wren=%b addr=%h wdata=%h required 1 0 0100 00000000",
                     mem_rden_out, mem_wren_out, mem_addr_out, mem_wdata_out);
        end
        mem_done_in  = 1'b1;
        mem_rdata_in = 32'h1234_5678;
        tick();
        mem_done_in  = 1'b0;
        mem_rdata_in = '0;
        checks++;
        if (ch_done_out !== 4'b0100 || ch_err_out !== 4'b0000) begin
            failures++;
            $display("FAIL read_done: done=%b err=%b required 0100 0000", ch_done_out, ch_err_out);
        end
        checks++;
        if (rdata_out !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_data: got %h required 12345678", rdata_out);
        end
        ch_rden_in = '0;
        tick();
        checks++;
        if (ch_done_out !== 4'b0000 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL read_idle: done=%b busy=%b required 0000 0", ch_done_out, busy_out);
        end
    endtask

    // ch0 write, memory completes in the second ACCESS cycle.
    task automatic test_write();
        int wr_cycles;
        wr_cycles = 0;
        ch_addr_in[0 +: c_ADDR_W]  = 16'h0010;
        ch_wdata_in[0 +: c_WORD_W] = 32'hDEAD_BEEF;
        ch_wren_in = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (mem_wren_out) wr_cycles++;
            checks++;
            if ({mem_rden_out, mem_addr_out, mem_wdata_out, busy_out} !== {1'b0, 16'h0010, 32'hDEAD_BEEF, 1'b1}) begin
                failures++;
                $display("FAIL write_hold%0d: rden=%b addr=%h wdata=%h busy=%b required 0 0010 deadbeef 1",
                         c, mem_rden_out, mem_addr_out, mem_wdata_out, busy_out);
            end
            if (c == 1) begin
                mem_done_in  = 1'b1;
                mem_rdata_in = 32'hFFFF_FFFF;
            end
        end
        tick();
        mem_done_in  = 1'b0;
        mem_rdata_in = '0;
        if (mem_wren_out) wr_cycles++;
        checks++;
        if (wr_cycles !== 2) begin
            failures++;
            $display("FAIL write_len: wren cycles %0d required 2", wr_cycles);
        end
        checks++;
        if (ch_done_out !== 4'b0001 || ch_err_out !== 4'b0000) begin
            failures++;
            $display("FAIL write_done: done=%b err=%b required 0001 0000", ch_done_out, ch_err_out);
        end
        checks++;
        if (rdata_out !== 32'h1234_5678 || mem_addr_out !== 16'h0 || mem_wdata_out !== 32'h0) begin
            failures++;
            $display("FAIL write_resp: rdata=%h addr=%h wdata=%h required 12345678 0000 00000000",
                     rdata_out, mem_addr_out, mem_wdata_out);
        end
        ch_wren_in = '0;
        tick();
    endtask

    // Continuous requests with instant memory; checks grant order and spacing.
    task automatic test_fairness(input logic [3:0] reqs, input int e0, input int e1,
                                 input int e2, input int e3, input string tag);
        int exp_ch[4];
        int n;
        exp_ch = '{e0, e1, e2, e3};
        mem_done_in  = 1'b1;
        mem_rdata_in = 32'hA5A5_0000;
        ch_rden_in   = reqs;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (ch_done_out === 4'b0000 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (ch_done_out !== (4'b0001 << exp_ch[g]) || n !== 2) begin
                failures++;
                $display("FAIL %s_grant%0d: done=%b after %0d cycles required ch%0d after 2",
                         tag, g, ch_done_out, n, exp_ch[g]);
            end
            if (g == 3) ch_rden_in = '0;
            tick();
        end
        mem_done_in = 1'b0;
        checks++;
        if (rdata_out !== 32'hA5A5_0000) begin
            failures++;
            $display("FAIL %s_rdata: got %h required a5a50000", tag, rdata_out);
        end
    endtask

    // ch0 raises rden and wren together: served as a single read.
    task automatic test_rd_wr_both();
        int rd = 0;
        int wr = 0;
        int nd = 0;
        logic [3:0] last = '0;
        ch_addr_in[0 +: c_ADDR_W] = 16'h0042;
        ch_rden_in   = 4'b0001;
        ch_wren_in   = 4'b0001;
        mem_done_in  = 1'b1;
        mem_rdata_in = 32'h0000_0042;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_rden_out) rd++;
            if (mem_wren_out) wr++;
            if (ch_done_out !== 4'b0000) begin
                nd++;
                last = ch_done_out;
                ch_rden_in = '0;
                ch_wren_in = '0;
            end
        end
        mem_done_in = 1'b0;
        checks++;
        if (rd !== 1 || wr !== 0) begin
            failures++;
            $display("FAIL both_enables: rden cycles %0d wren cycles %0d required 1 0", rd, wr);
        end
        checks++;
        if (nd !== 1 || last !== 4'b0001 || rdata_out !== 32'h0000_0042) begin
            failures++;
            $display("FAIL both_done: pulses %0d done=%b rdata=%h required 1 0001 00000042",
                     nd, last, rdata_out);
        end
    endtask

    // ch0 read never completes; ch1 waits and is served next.
    task automatic test_timeout();
        int n = 0;
        int rd = 0;
        ch_rden_in  = 4'b0011;
        mem_done_in = 1'b0;
        while (ch_done_out === 4'b0000 && n < 12) begin
            tick();
            n++;
            if (mem_rden_out) rd++;
        end
        checks++;
        if (rd !== 4 || ch_done_out !== 4'b0001 || ch_err_out !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_pulse: rden cycles %0d done=%b err=%b required 4 0001 0001",
                     rd, ch_done_out, ch_err_out);
        end
        checks++;
        if (rdata_out !== 32'h0) begin
            failures++;
            $display("FAIL timeout_rdata: got %h required 00000000", rdata_out);
        end
        ch_rden_in   = 4'b0010;
        mem_done_in  = 1'b1;
        mem_rdata_in = 32'hCAFE_0001;
        tick();
        n = 0;
        while (ch_done_out === 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ch_done_out !== 4'b0010 || ch_err_out !== 4'b0000 || rdata_out !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL timeout_next: done=%b err=%b rdata=%h required 0010 0000 cafe0001",
                     ch_done_out, ch_err_out, rdata_out);
        end
        ch_rden_in  = '0;
        mem_done_in = 1'b0;
        tick();
    endtask

    // Reset in the second ACCESS cycle of a ch1 write, then ch3 is served.
    task automatic test_reset_mid_op();
        int n = 0;
        logic [c_ADDR_W-1:0] seen_addr = '0;
        ch_addr_in[1*c_ADDR_W +: c_ADDR_W]  = 16'h0200;
        ch_wdata_in[1*c_WORD_W +: c_WORD_W] = 32'h1111_2222;
        ch_wren_in = 4'b0010;
        tick();
        tick();
        checks++;
        if (mem_wren_out !== 1'b1 || mem_addr_out !== 16'h0200) begin
            failures++;
            $display("FAIL midrst_access: wren=%b addr=%h required 1 0200", mem_wren_out, mem_addr_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ch_done_out, ch_err_out, busy_out, mem_rden_out, mem_wren_out,
             mem_addr_out, mem_wdata_out} !== '0) begin
            failures++;
            $display("FAIL midrst_clear: done=%b err=%b busy=%b rden=%b wren=%b addr=%h wdata=%h required all 0",
                     ch_done_out, ch_err_out, busy_out, mem_rden_out, mem_wren_out,
                     mem_addr_out, mem_wdata_out);
        end
        rst        = 1'b0;
        ch_wren_in = '0;
        ch_addr_in[3*c_ADDR_W +: c_ADDR_W] = 16'h0300;
        ch_rden_in   = 4'b1000;
        mem_done_in  = 1'b1;
        mem_rdata_in = 32'h3333_3333;
        while (ch_done_out === 4'b0000 && n < 10) begin
            tick();
            n++;
            if (mem_rden_out) seen_addr = mem_addr_out;
        end
        checks++;
        if (ch_done_out !== 4'b1000 || seen_addr !== 16'h0300 || rdata_out !== 32'h3333_3333) begin
            failures++;
            $display("FAIL midrst_next: done=%b addr=%h rdata=%h required 1000 0300 33333333",
                     ch_done_out, seen_addr, rdata_out);
        end
        ch_rden_in  = '0;
        mem_done_in = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_fairness(4'b1010, 1, 3, 1, 3, "rr_two");
        test_rd_wr_both();
        test_fairness(4'b1011, 1, 3, 0, 1, "rr_three");
        test_timeout();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_rw_arbiter.md
Name: mem_rw_arbiter

Overview:
- Parametrised successor to the single-client read/write FSM.
- Arbitrates up to NUM_CH independent clients onto one RAM read/write port using round-robin.
- Holds address and data stable for the whole access, waits for a memory completion flag, and returns read data plus a one-cycle done pulse to the granted client.
- Adds a bounded timeout with an error flag. Sits between the Fetch/eval clients and RAM.

Parameters:
- NUM_CH, 4, number of client channels (1..16).
- WORD_W, 32, data word width (WORD_SIZE in the lisp package).
- ADDR_W, 16, address width.
- TIMEOUT, 255, max cycles to wait for mem_done_in; 0 = wait forever.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ch_rden_in  in  NUM_CH  per-channel read request, level, held until ch_done_out
- ch_wren_in  in  NUM_CH  per-channel write request, level, held until ch_done_out
- ch_addr_in  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata_in  in  NUM_CH*WORD_W  per-channel write data, same packing
- ch_done_out  out  NUM_CH  one-cycle completion pulse, one-hot
- ch_err_out  out  NUM_CH  one-cycle timeout pulse, coincident with ch_done_out
- rdata_out  out  WORD_W  read data for the channel currently pulsing done
- busy_out  out  1  high whenever state != IDLE
- mem_rden_out  out  1  RAM read enable
- mem_wren_out  out  1  RAM write enable
- mem_addr_out  out  ADDR_W  RAM address
- mem_wdata_out  out  WORD_W  RAM write data
- mem_rdata_in  in  WORD_W  RAM read data, valid when mem_done_in is high
- mem_done_in  in  1  RAM reports that the current operation is complete

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state is IDLE; round-robin pointer rr_ptr is 0; timeout counter is 0.
- Reset mid-operation: mem enables drop in the next cycle; no done or error pulse is issued.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - A channel is pending when rden|wren is set for it.
  - Grant the first pending channel searching from rr_ptr upward, wrapping NUM_CH-1 -> 0.
  - Latch the channel index, op (read if rden, else write), addr and wdata.
  - Go to ACCESS. No pending channel: stay in IDLE.
- ACCESS:
  - mem_rden_out or mem_wren_out (exactly one) is high from the first ACCESS cycle until the cycle after mem_done_in is sampled.
  - mem_addr_out is constant during ACCESS. mem_wdata_out equals the latched wdata for writes and is 0 for reads.
  - mem_done_in is sampled only in ACCESS and is ignored in IDLE and RESP.
  - On sampling mem_done_in=1: capture mem_rdata_in (reads only), go to RESP.
- Timeout:
  - The counter increments each ACCESS cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with mem_done_in still low, go to RESP with the error flag set and rdata_out = 0.
  - mem_done_in arriving on the same cycle the counter reaches TIMEOUT counts as success, not timeout.
- RESP (one cycle):
  - ch_done_out[ch] = 1 and ch_err_out[ch] = err; mem enables and mem_addr_out/mem_wdata_out are 0.
  - rdata_out holds its value until the next read completes; a write completion leaves it unchanged.
  - rr_ptr <= ch+1, wrapping to 0.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle n -> mem enable high at n+1. mem_done_in sampled at cycle m -> ch_done_out high at m+1.
  - Minimum turnaround is 3 cycles with a same-cycle memory completion.
  - Back-to-back grants are separated by one IDLE cycle.
- Client rule: deassert the request in the cycle after ch_done_out. A request still high in the following IDLE is treated as a new request.
- Simultaneous rden and wren on one channel: the read is served; the write is ignored for that grant.
- Requests arriving while busy wait in place; no queueing beyond the held levels.
- NUM_CH=1: rr_ptr stays 0 and behaviour degenerates to the single-client FSM.

Test Plan:
- Single write, ch0, addr 0x0010, data 0xDEADBEEF, mem_done_in 2 cycles after enable:
  - mem_wren_out high for exactly 2 cycles with addr/data stable.
  - ch_done_out = 4'b0001 for 1 cycle; ch_err_out = 0.
- Read, ch2, addr 0x0100, mem_rdata_in 0x12345678 with mem_done_in on the first ACCESS cycle:
  - ch_done_out[2] pulses 2 cycles after the request; rdata_out = 0x12345678.
- Fairness: ch1 and ch3 hold reads continuously with instant memory:
  - Grants alternate 1,3,1,3.
  - Adding ch0 gives 1,3,0,1 order from rr_ptr.
- Timeout, TIMEOUT=4, ch0 read, mem_done_in never asserted:
  - Enable high for 4 cycles; ch_done_out[0] and ch_err_out[0] pulse together; rdata_out = 0; ch1 is served next.
- Reset asserted in the 2nd ACCESS cycle of a ch1 write:
  - Next cycle all outputs are 0 with no done pulse.
  - After reset releases, a ch3 request is granted before ch1 (rr_ptr = 0 search order with ch1 dropped).
- ch0 asserts rden and wren together, addr 0x0042: only mem_rden_out toggles; one done pulse.
